// File: rtl/rfsoc_config.sv
// Shared RFSoC constants: stream widths, GPIO control bit indices, and the
// state encoding of the PS-to-PL word packer.
package rfsoc_config;

  localparam int ps_axis_width = 32;

  // GPIO control bit indices. ADC and DAC flush requests live on different bits.
  localparam int adc_buffer_flush = 0;
  localparam int dac_buffer_flush = 1;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FULL = 2'd1
  } pack_state_e;

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_FULL = 2'd1;

endpackage

// File: rtl/axis_ps_to_pl.sv
// Packs narrow PS DMA stream beats into wide PL words for the DAC sample FIFO.
// A word closed early by tlast is zero-padded; the gpio flush bit drops in-flight data.
module axis_ps_to_pl
  import rfsoc_config::*;
#(
  parameter int PL_WIDTH = 128,
  parameter int PS_WIDTH = ps_axis_width
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PS_WIDTH-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic [PL_WIDTH-1:0] m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  input  logic [15:0]         gpio_ctrl,
  output logic [31:0]         word_count,
  output logic [15:0]         pad_count,
  output logic [1:0]          dbg_state
);

  localparam int WORDS  = PL_WIDTH / PS_WIDTH;
  localparam int LANE_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORDS - 1);

  // Handshake rules on both ports: a beat transfers on a rising clk edge where
  // tvalid and tready are both high; tvalid never waits on tready, and a raised
  // m_axis_tvalid holds its word stable until accepted (flush excepted).

  logic [1:0]          state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [PL_WIDTH-1:0] asm_q, asm_d;
  logic                asm_last_q, asm_last_d;
  logic                asm_pad_q, asm_pad_d;
  logic [PL_WIDTH-1:0] out_q, out_d;
  logic                out_last_q, out_last_d;
  logic                out_pad_q, out_pad_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         word_count_q, word_count_d;
  logic [15:0]         pad_count_q, pad_count_d;

  logic                flush;
  logic                accept;
  logic                out_free;
  logic                hs_out;
  logic                word_done;
  logic                beat_pad;
  logic [PL_WIDTH-1:0] asm_beat;

  // The remaining gpio bits control other blocks.
  logic unused_gpio;
  assign unused_gpio = ^gpio_ctrl;

  assign flush         = gpio_ctrl[dac_buffer_flush];
  assign s_axis_tready = (state_q == ST_FILL) && !flush && !rst;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign out_free      = !out_valid_q || m_axis_tready;
  assign hs_out        = out_valid_q && m_axis_tready;
  assign word_done     = accept && (s_axis_tlast || (lane_q == LAST_LANE));
  assign beat_pad      = (lane_q != LAST_LANE);

  // Lane 0 starts a fresh word, so stale upper lanes never leak into a padded word.
  always_comb begin
    asm_beat = (lane_q == '0) ? '0 : asm_q;
    for (int k = 0; k < WORDS; k++) begin
      if (lane_q == LANE_W'(k)) begin
        asm_beat[k*PS_WIDTH +: PS_WIDTH] = s_axis_tdata;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    asm_d        = asm_q;
    asm_last_d   = asm_last_q;
    asm_pad_d    = asm_pad_q;
    out_d        = out_q;
    out_last_d   = out_last_q;
    out_pad_d    = out_pad_q;
    out_valid_d  = out_valid_q && !m_axis_tready;
    word_count_d = word_count_q;
    pad_count_d  = pad_count_q;

    if (hs_out && !flush) begin
      word_count_d = word_count_q + 32'd1;
      if (out_pad_q && (pad_count_q != 16'hFFFF)) begin
        pad_count_d = pad_count_q + 16'd1;
      end
    end

    if (flush) begin
      state_d     = ST_FILL;
      lane_d      = '0;
      asm_d       = '0;
      asm_last_d  = 1'b0;
      asm_pad_d   = 1'b0;
      out_d       = '0;
      out_last_d  = 1'b0;
      out_pad_d   = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept) begin
            asm_d = asm_beat;
            if (!word_done) begin
              lane_d = lane_q + LANE_W'(1);
            end else if (out_free) begin
              out_d       = asm_beat;
              out_last_d  = s_axis_tlast;
              out_pad_d   = beat_pad;
              out_valid_d = 1'b1;
              lane_d      = '0;
            end else begin
              asm_last_d = s_axis_tlast;
              asm_pad_d  = beat_pad;
              state_d    = ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (out_free) begin
            out_d       = asm_q;
            out_last_d  = asm_last_q;
            out_pad_d   = asm_pad_q;
            out_valid_d = 1'b1;
            lane_d      = '0;
            state_d     = ST_FILL;
          end
        end
        default: begin
          state_d     = ST_FILL;
          lane_d      = '0;
          asm_d       = '0;
          asm_last_d  = 1'b0;
          asm_pad_d   = 1'b0;
          out_d       = '0;
          out_last_d  = 1'b0;
          out_pad_d   = 1'b0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FILL;
      lane_q       <= '0;
      asm_q        <= '0;
      asm_last_q   <= 1'b0;
      asm_pad_q    <= 1'b0;
      out_q        <= '0;
      out_last_q   <= 1'b0;
      out_pad_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      word_count_q <= '0;
      pad_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      asm_q        <= asm_d;
      asm_last_q   <= asm_last_d;
      asm_pad_q    <= asm_pad_d;
      out_q        <= out_d;
      out_last_q   <= out_last_d;
      out_pad_q    <= out_pad_d;
      out_valid_q  <= out_valid_d;
      word_count_q <= word_count_d;
      pad_count_q  <= pad_count_d;
    end
  end

  assign m_axis_tdata  = out_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign word_count    = word_count_q;
  assign pad_count     = pad_count_q;
  assign dbg_state     = state_q;

endmodule
